// File: rtl/rv32i_mem_arbiter_pkg.sv
// rv32i_mem_arbiter_pkg: shared FSM encoding and fetch constants for the memory arbiter
package rv32i_mem_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INST_WAIT = 2'd1,
    DATA_WAIT = 2'd2,
    RESP      = 2'd3
  } state_t;
  localparam logic [3:0] FETCH_SEL = 4'b1111;
endpackage

// File: rtl/rv32i_arb_timeout.sv
// rv32i_arb_timeout: down-counter that flags the TIMEOUT-th enabled cycle after a load
module rv32i_arb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  // reload on entry to a wait state, then count down each waiting cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt <= '0;
    else if (load) cnt <= W'(TIMEOUT);
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  end
  assign expire = (TIMEOUT != 0) && en && (cnt == W'(1));
endmodule

// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: shares one single-port memory between instruction fetch and load/store
module rv32i_mem_arbiter
  import rv32i_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stb_inst,
  input  logic [31:0] i_iaddr,
  input  logic        i_flush_inst,
  output logic        o_ack_inst,
  output logic [31:0] o_inst,
  output logic        o_err_inst,
  input  logic        i_stb_data,
  input  logic        i_we_data,
  input  logic [31:0] i_addr_data,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_sel_data,
  output logic        o_ack_data,
  output logic [31:0] o_rdata,
  output logic        o_err_data,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_sel,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);
  localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  state_t state, state_n;
  logic [SW-1:0] starve_cnt;
  logic grant_d, grant_i, wait_st, done, expire, timed_out;
  logic drop_q, ack_inst_q, ack_data_q, err_inst_q, err_data_q;
  rv32i_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .load    (state == IDLE && state_n != IDLE),
    .en      (wait_st),
    .expire  (expire)
  );
  // arbitration, completion detection and next-state selection
  always_comb begin
    grant_d   = i_stb_data && !(i_stb_inst && starve_cnt == SW'(STARVE_LIMIT));
    grant_i   = !grant_d && i_stb_inst && !i_flush_inst;
    wait_st   = state == INST_WAIT || state == DATA_WAIT;
    done      = wait_st && o_mem_req && (i_mem_ack || expire);
    timed_out = !i_mem_ack;
    state_n   = state;
    case (state)
      IDLE:                 state_n = grant_d ? DATA_WAIT : grant_i ? INST_WAIT : IDLE;
      INST_WAIT, DATA_WAIT: state_n = done ? RESP : state;
      default:              state_n = IDLE;
    endcase
  end
  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else state <= state_n;
  end
  // fetch starvation counter, only meaningful while fetch is waiting in IDLE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) starve_cnt <= '0;
    else if (state == IDLE) begin
      if (!i_stb_inst || grant_i) starve_cnt <= '0;
      else if (grant_d && starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
    end
  end
  // memory request launch/hold and registered response delivery to the owner
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_sel   <= '0;
      o_inst      <= '0;
      o_rdata     <= '0;
      drop_q      <= 1'b0;
      ack_inst_q  <= 1'b0;
      ack_data_q  <= 1'b0;
      err_inst_q  <= 1'b0;
      err_data_q  <= 1'b0;
    end else begin
      ack_inst_q <= 1'b0;
      ack_data_q <= 1'b0;
      err_inst_q <= 1'b0;
      err_data_q <= 1'b0;
      if (state == IDLE && (grant_d || grant_i)) begin
        o_mem_req   <= 1'b1;
        o_mem_we    <= grant_d && i_we_data;
        o_mem_addr  <= grant_d ? i_addr_data : i_iaddr;
        o_mem_wdata <= grant_d ? i_wdata : '0;
        o_mem_sel   <= grant_d ? i_sel_data : FETCH_SEL;
        drop_q      <= 1'b0;
      end
      if (state == INST_WAIT && i_flush_inst) drop_q <= 1'b1;
      if (done) begin
        o_mem_req <= 1'b0;
        if (state == INST_WAIT) begin
          if (!(drop_q || i_flush_inst)) begin
            ack_inst_q <= 1'b1;
            err_inst_q <= timed_out;
            o_inst     <= timed_out ? '0 : i_mem_rdata;
          end
        end else begin
          ack_data_q <= 1'b1;
          err_data_q <= timed_out;
          o_rdata    <= timed_out ? '0 : i_mem_rdata;
        end
      end
    end
  end
  assign o_ack_inst = ack_inst_q && !i_flush_inst;
  assign o_err_inst = err_inst_q && !i_flush_inst;
  assign o_ack_data = ack_data_q;
  assign o_err_data = err_data_q;
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb_rv32i_mem_arbiter: directed self-checking bench for the fetch/data memory arbiter
module tb_rv32i_mem_arbiter;
  localparam logic [31:0] MAGIC = 32'h5A5A_0F0F;
  logic clk, rst_n;
  logic stb_inst, flush_inst, stb_data, we_data;
  logic [31:0] iaddr, addr_data, wdata;
  logic [3:0] sel_data;
  logic ack_inst, err_inst, ack_data, err_data;
  logic [31:0] inst, rdata;
  logic mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_sel;
  logic mem_ack_q, force_ack, mem_on;
  logic [31:0] wr_addr, wr_data;
  int mem_lat, lat_cnt, cyc, n_ai, n_ad, both;
  int checks = 0, errors = 0;

  rv32i_mem_arbiter #(.STARVE_LIMIT(2), .TIMEOUT(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_stb_inst(stb_inst), .i_iaddr(iaddr), .i_flush_inst(flush_inst),
    .o_ack_inst(ack_inst), .o_inst(inst), .o_err_inst(err_inst),
    .i_stb_data(stb_data), .i_we_data(we_data), .i_addr_data(addr_data),
    .i_wdata(wdata), .i_sel_data(sel_data),
    .o_ack_data(ack_data), .o_rdata(rdata), .o_err_data(err_data),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_sel(mem_sel),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem_addr ^ MAGIC;
  assign mem_ack   = mem_ack_q | force_ack;

  // memory model: acks mem_lat cycles after it first sees a request
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ack_q <= 1'b0;
      lat_cnt   <= 0;
    end else begin
      mem_ack_q <= 1'b0;
      if (mem_on && mem_req && !mem_ack_q) begin
        if (lat_cnt + 1 >= mem_lat) begin
          mem_ack_q <= 1'b1;
          lat_cnt   <= 0;
          if (mem_we) begin
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
          end
        end else lat_cnt <= lat_cnt + 1;
      end else lat_cnt <= 0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ack pulse bookkeeping
  always @(negedge clk) begin
    if (ack_inst) n_ai <= n_ai + 1;
    if (ack_data) n_ad <= n_ad + 1;
    if (ack_inst && ack_data) both <= both + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic sig(input int w);
    return w == 0 ? ack_inst : w == 1 ? ack_data : w == 2 ? (ack_inst | ack_data) : mem_req;
  endfunction

  task automatic wait_sig(input string tag, input int w, output int t);
    int n = 0;
    logic hit = 1'b0;
    while (!hit && n < 60) begin
      tick();
      n++;
      hit = sig(w);
    end
    t = cyc;
    chk(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    int t0, t1, t2, hi, n0, bad;
    logic [5:0] ord;
    cyc = 0; n_ai = 0; n_ad = 0; both = 0;
    rst_n = 1'b0; stb_inst = 0; flush_inst = 0; stb_data = 0; we_data = 0;
    iaddr = 0; addr_data = 0; wdata = 0; sel_data = 0;
    force_ack = 0; mem_on = 1; mem_lat = 1; wr_addr = 0; wr_data = 0;
    tick(); tick();
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_ack_inst", 32'(ack_inst), 0);
    chk("rst_ack_data", 32'(ack_data), 0);
    chk("rst_inst", inst, 0);
    chk("rst_addr", mem_addr, 0);
    rst_n = 1'b1;
    tick();
    // fetch-only stream at 0,4,8 with a one-cycle memory
    stb_inst = 1; iaddr = 32'h0;
    wait_sig("f0_ack", 0, t0);
    chk("f0_inst", inst, 32'h0 ^ MAGIC);
    chk("f0_sel", 32'(mem_sel), 32'hF);
    iaddr = 32'h4;
    wait_sig("f1_ack", 0, t1);
    chk("f1_inst", inst, 32'h4 ^ MAGIC);
    chk("f1_period", 32'(t1 - t0), 4);
    iaddr = 32'h8;
    wait_sig("f2_ack", 0, t2);
    chk("f2_inst", inst, 32'h8 ^ MAGIC);
    chk("f2_period", 32'(t2 - t1), 4);
    chk("f2_we", 32'(mem_we), 0);
    stb_inst = 0;
    tick();
    chk("f_pulse", 32'(ack_inst), 0);
    tick();
    // both requesters held with STARVE_LIMIT=2: D,D,I,D,D,I
    stb_inst = 1; iaddr = 32'h40;
    stb_data = 1; we_data = 0; addr_data = 32'h8000; sel_data = 4'hF;
    ord = '0;
    for (int i = 0; i < 6; i++) begin
      wait_sig("starve_ack", 2, t0);
      ord[i] = ack_inst;
      if (ack_data) chk("starve_rdata", rdata, 32'h8000 ^ MAGIC);
    end
    chk("starve_order", 32'(ord), 32'b100100);
    stb_inst = 0; stb_data = 0;
    tick(); tick();
    // store with three-cycle memory, fields held stable
    mem_lat = 3;
    stb_data = 1; we_data = 1; addr_data = 32'h100; wdata = 32'hDEADBEEF; sel_data = 4'b0011;
    wait_sig("st_req", 3, t0);
    chk("st_we", 32'(mem_we), 1);
    chk("st_addr", mem_addr, 32'h100);
    chk("st_wdata", mem_wdata, 32'hDEADBEEF);
    chk("st_sel", 32'(mem_sel), 32'h3);
    bad = 0; hi = 0;
    while (!ack_data && hi < 60) begin
      if (mem_req && (mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF || mem_sel !== 4'b0011)) bad++;
      tick();
      hi++;
    end
    chk("st_ack", 32'(ack_data), 1);
    chk("st_stable", 32'(bad), 0);
    chk("st_err", 32'(err_data), 0);
    chk("st_mem_wr", wr_data, 32'hDEADBEEF);
    stb_data = 0; we_data = 0;
    tick();
    chk("st_pulse", 32'(ack_data), 0);
    tick();
    // fetch flushed in flight; the refetch at the new PC is the only ack
    n0 = n_ai;
    stb_inst = 1; iaddr = 32'h200;
    wait_sig("fl_req", 3, t0);
    flush_inst = 1; iaddr = 32'h300;
    tick();
    flush_inst = 0;
    wait_sig("fl_ack", 0, t1);
    chk("fl_inst", inst, 32'h300 ^ MAGIC);
    chk("fl_addr", mem_addr, 32'h300);
    stb_inst = 0;
    tick();
    chk("fl_count", 32'(n_ai - n0), 1);
    tick();
    // load timeout with a silent memory, then a late ack
    mem_on = 0; mem_lat = 1;
    stb_data = 1; addr_data = 32'h9000;
    wait_sig("to_req", 3, t0);
    hi = 1;
    while (hi < 50) begin
      tick();
      if (!mem_req) break;
      hi++;
    end
    chk("to_req_cycles", 32'(hi), 8);
    chk("to_ack", 32'(ack_data), 1);
    chk("to_err", 32'(err_data), 1);
    chk("to_rdata", rdata, 0);
    stb_data = 0;
    force_ack = 1;
    n0 = n_ad;
    tick(); tick();
    force_ack = 0;
    tick(); tick(); tick();
    chk("late_ack_count", 32'(n_ad - n0), 0);
    chk("late_req", 32'(mem_req), 0);
    chk("late_err", 32'(err_data), 0);
    // async reset in DATA_WAIT, then a fresh load completes
    stb_data = 1; addr_data = 32'hA000;
    wait_sig("rs_req", 3, t0);
    #2 rst_n = 0;
    #1;
    chk("rs_req_low", 32'(mem_req), 0);
    chk("rs_acks", 32'({ack_inst, ack_data}), 0);
    mem_on = 1;
    tick();
    rst_n = 1;
    wait_sig("rs_ack", 1, t1);
    chk("rs_rdata", rdata, 32'hA000 ^ MAGIC);
    chk("rs_err", 32'(err_data), 0);
    stb_data = 0;
    tick(); tick();
    chk("never_both", 32'(both), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
